mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory bus between two requesters: the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Grants the bus to one requester at a time and runs the bus valid/ack handshake.
- Produces stall signals so the stages hold until their access completes.
- Supports a fetch flush that squashes a fetch already in flight without aborting the bus transaction.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, number of consecutive data grants while a fetch waits, after which fetch gets priority for one grant (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch read request, level, held until i_ready.
- i_addr  in  AW  fetch address.
- i_flush  in  1  fetch squashed (branch/jump taken).
- i_rdata  out  DW  fetched instruction, valid when i_ready.
- i_ready  out  1  one-cycle pulse, fetch complete.
- d_req  in  1  data request, level, held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_sel  in  DW/8  byte enables.
- d_rdata  out  DW  load data, valid when d_ready.
- d_ready  out  1  one-cycle pulse, data access complete.
- stallF  out  1  fetch stage must hold.
- stallM  out  1  memory stage must hold.
- m_req  out  1  bus request, held until m_ack.
- m_we  out  1  bus write enable.
- m_addr  out  AW  bus address.
- m_wdata  out  DW  bus write data.
- m_sel  out  DW/8  bus byte enables.
- m_rdata  in  DW  bus read data, valid with m_ack.
- m_ack  in  1  bus completion, single cycle.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE.
  - All outputs 0, including i_rdata/d_rdata; starve counter = 0; discard flag = 0.
  - A transaction in flight is abandoned; the bench must not ack after reset.
- States: IDLE, IBUSY, DBUSY.
- IDLE:
  - If d_req and (starve count < STARVE_LIMIT or !i_req): latch d_we/d_addr/d_wdata/d_sel into the bus registers and go to DBUSY. If i_req was pending, increment the starve counter, saturating at 15.
  - Else if i_req and !i_flush: latch i_addr (m_we=0, m_sel all ones), go to IBUSY, clear the starve counter.
  - Else stay in IDLE.
- Bus registers: m_req=1 and the m_* fields are registered, valid from the cycle after the grant and held stable until m_ack.
- DBUSY, on m_ack:
  - m_req=0.
  - d_rdata <= m_rdata for a load; unchanged for a store.
  - d_ready pulses 1 the next cycle; return to IDLE.
- IBUSY, on m_ack:
  - m_req=0.
  - If the discard flag is clear: i_rdata <= m_rdata and i_ready pulses the next cycle.
  - If the discard flag is set: no i_ready, i_rdata unchanged, discard cleared.
  - Return to IDLE.
- Flush:
  - i_flush while in IBUSY sets the discard flag. The bus transaction always completes.
  - i_flush in IDLE blocks a fetch grant that cycle only.
- Minimum access latency: request in cycle N, grant at edge N, m_req in N+1, m_ack earliest N+1, ready pulse in N+2. This allows back-to-back accesses every 2 cycles.
- Stalls (combinational from state and requests):
  - stallF = i_req & !i_ready.
  - stallM = d_req & !d_ready.
  - Both deassert in the cycle of the ready pulse.
- Simultaneous events:
  - A new request arriving in the cycle m_ack arrives is not granted until IDLE, i.e. the following cycle.
  - m_ack while in IDLE is ignored.
  - d_req and i_req both present: data wins unless the starve counter has reached STARVE_LIMIT.
- Requesters must not change address or data while their req is high and ready has not pulsed. Behaviour is undefined otherwise.

Test Plan:
1. Reset mid-DBUSY (rst pulse asynchronous to clk) -> m_req, d_ready, stallM, and i_rdata/d_rdata go 0 immediately; state IDLE.
2. Single fetch: i_addr=0xBFC00000, m_ack after 3 wait cycles with m_rdata=0x24080001 -> m_addr=0xBFC00000, m_we=0, m_sel=4'hF held for 3 cycles; i_ready pulses once with i_rdata=0x24080001; stallF high for 5 cycles.
3. Simultaneous i_req and d_req (store, d_addr=0x80000010, d_wdata=0xDEADBEEF, d_sel=4'b0011) -> data granted first with m_we=1 and m_sel=4'b0011; fetch served immediately after; stallF spans both accesses.
4. Continuous d_req with i_req held, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes; the counter clears on the fetch grant.
5. i_flush asserted in the second cycle of IBUSY, m_ack=1 with m_rdata=0x12345678 -> no i_ready pulse, i_rdata keeps its old value; the next fetch is granted normally.
6. Load back-to-back with zero-wait ack (m_ack in the first m_req cycle) -> d_rdata=m_rdata and d_ready every 2 cycles; m_ack injected in IDLE has no effect.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch and memory pipeline stages.
// Data has priority unless fetch has been starved for STARVE_LIMIT grants.
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_flush,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_sel,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ready,
    output logic            stallF,
    output logic            stallM,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_sel,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack
);
    localparam int unsigned SW        = DW / 8;
    localparam logic [3:0]  StarveLim = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} stateE;

    stateE           stateQ, stateD;
    logic [3:0]      starveQ, starveD;
    logic            discardQ, discardD;
    logic            mReqQ, mReqD;
    logic            mWeQ, mWeD;
    logic [AW-1:0]   mAddrQ, mAddrD;
    logic [DW-1:0]   mWdataQ, mWdataD;
    logic [SW-1:0]   mSelQ, mSelD;
    logic            iReadyQ, iReadyD;
    logic            dReadyQ, dReadyD;
    logic [DW-1:0]   iRdataQ, iRdataD;
    logic [DW-1:0]   dRdataQ, dRdataD;
    logic            dropFetch;

    always_comb begin
        stateD    = stateQ;
        starveD   = starveQ;
        discardD  = discardQ;
        mReqD     = mReqQ;
        mWeD      = mWeQ;
        mAddrD    = mAddrQ;
        mWdataD   = mWdataQ;
        mSelD     = mSelQ;
        iReadyD   = 1'b0;
        dReadyD   = 1'b0;
        iRdataD   = iRdataQ;
        dRdataD   = dRdataQ;
        // A flush landing in the ack cycle still squashes that fetch.
        dropFetch = discardQ | i_flush;
        unique case (stateQ)
            StIdle: begin
                if (d_req && ((starveQ < StarveLim) || !i_req)) begin
                    mReqD   = 1'b1;
                    mWeD    = d_we;
                    mAddrD  = d_addr;
                    mWdataD = d_wdata;
                    mSelD   = d_sel;
                    stateD  = StDBusy;
                    if (i_req && (starveQ != 4'hF)) begin
                        starveD = starveQ + 4'd1;
                    end
                end else if (i_req && !i_flush) begin
                    mReqD   = 1'b1;
                    mWeD    = 1'b0;
                    mAddrD  = i_addr;
                    mSelD   = {SW{1'b1}};
                    stateD  = StIBusy;
                    starveD = 4'd0;
                end
            end
            StDBusy: begin
                if (m_ack) begin
                    mReqD   = 1'b0;
                    dReadyD = 1'b1;
                    stateD  = StIdle;
                    if (!mWeQ) begin
                        dRdataD = m_rdata;
                    end
                end
            end
            StIBusy: begin
                if (i_flush) begin
                    discardD = 1'b1;
                end
                if (m_ack) begin
                    mReqD    = 1'b0;
                    discardD = 1'b0;
                    stateD   = StIdle;
                    if (!dropFetch) begin
                        iRdataD = m_rdata;
                        iReadyD = 1'b1;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= StIdle;
            starveQ  <= 4'd0;
            discardQ <= 1'b0;
            mReqQ    <= 1'b0;
            mWeQ     <= 1'b0;
            mAddrQ   <= '0;
            mWdataQ  <= '0;
            mSelQ    <= '0;
            iReadyQ  <= 1'b0;
            dReadyQ  <= 1'b0;
            iRdataQ  <= '0;
            dRdataQ  <= '0;
        end else begin
            stateQ   <= stateD;
            starveQ  <= starveD;
            discardQ <= discardD;
            mReqQ    <= mReqD;
            mWeQ     <= mWeD;
            mAddrQ   <= mAddrD;
            mWdataQ  <= mWdataD;
            mSelQ    <= mSelD;
            iReadyQ  <= iReadyD;
            dReadyQ  <= dReadyD;
            iRdataQ  <= iRdataD;
            dRdataQ  <= dRdataD;
        end
    end

    assign m_req   = mReqQ;
    assign m_we    = mWeQ;
    assign m_addr  = mAddrQ;
    assign m_wdata = mWdataQ;
    assign m_sel   = mSelQ;
    assign i_ready = iReadyQ;
    assign d_ready = dReadyQ;
    assign i_rdata = iRdataQ;
    assign d_rdata = dRdataQ;

    // Stalls are forced low while reset is held so every output reads 0.
    assign stallF = i_req & ~iReadyQ & ~rst;
    assign stallM = d_req & ~dReadyQ & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bus responder task plus hand-computed expectations.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_flush = 1'b0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [SW-1:0] d_sel = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          stallF;
    logic          stallM;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int stallFCnt = 0;
    logic countF = 1'b0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .d_rdata(d_rdata), .d_ready(d_ready), .stallF(stallF), .stallM(stallM),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (countF && stallF) stallFCnt++;
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for m_req, checks the bus fields, holds for `waits` cycles, then acks.
    // Returns in the cycle where the ready pulse is visible.
    task automatic serveBus(input string tag, input int waits, input logic [DW-1:0] rdata,
                            input logic expWe, input logic [AW-1:0] expAddr,
                            input logic [DW-1:0] expWdata, input logic [SW-1:0] expSel);
        int n = 0;
        while (m_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkEq({tag, ".req"}, m_req, 1);
        if (m_req === 1'b1) begin
            checkEq({tag, ".we"}, m_we, expWe);
            checkEq({tag, ".addr"}, m_addr, expAddr);
            checkEq({tag, ".sel"}, m_sel, expSel);
            if (expWe) checkEq({tag, ".wdata"}, m_wdata, expWdata);
            for (int w = 0; w < waits; w++) begin
                step();
                checkEq({tag, ".holdReq"}, m_req, 1);
                checkEq({tag, ".holdAddr"}, m_addr, expAddr);
                checkEq({tag, ".holdSel"}, m_sel, expSel);
            end
            m_ack = 1'b1;
            m_rdata = rdata;
            step();
            m_ack = 1'b0;
            m_rdata = 32'hFFFF_FFFF;
            checkEq({tag, ".drop"}, m_req, 0);
        end
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkEq("rst.m_req", m_req, 0);
        checkEq("rst.i_ready", i_ready, 0);
        checkEq("rst.d_ready", d_ready, 0);
        checkEq("rst.i_rdata", i_rdata, 0);
        checkEq("rst.d_rdata", d_rdata, 0);
        checkEq("rst.stallF", stallF, 0);
        rst = 1'b0;
        step();

        // Single fetch, three wait cycles
        stallFCnt = 0;
        countF = 1'b1;
        i_req = 1'b1;
        i_addr = 32'hBFC0_0000;
        #1;
        checkEq("fetch.stallF", stallF, 1);
        serveBus("fetch", 3, 32'h2408_0001, 1'b0, 32'hBFC0_0000, '0, 4'hF);
        checkEq("fetch.i_ready", i_ready, 1);
        checkEq("fetch.i_rdata", i_rdata, 32'h2408_0001);
        checkEq("fetch.stallFlow", stallF, 0);
        i_req = 1'b0;
        step();
        countF = 1'b0;
        checkEq("fetch.pulseOnce", i_ready, 0);
        checkEq("fetch.stallCycles", stallFCnt, 5);

        // Back-to-back zero-wait loads
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_1000;
        d_sel = 4'hF;
        serveBus("ld0", 0, 32'h1111_1111, 1'b0, 32'h0000_1000, '0, 4'hF);
        checkEq("ld0.d_ready", d_ready, 1);
        checkEq("ld0.d_rdata", d_rdata, 32'h1111_1111);
        d_addr = 32'h0000_1004;
        #1;
        checkEq("ld0.stallM", stallM, 0);
        step();
        checkEq("ld1.grantNext", m_req, 1);
        checkEq("ld1.readyPulse", d_ready, 0);
        serveBus("ld1", 0, 32'h2222_2222, 1'b0, 32'h0000_1004, '0, 4'hF);
        checkEq("ld1.d_ready", d_ready, 1);
        checkEq("ld1.d_rdata", d_rdata, 32'h2222_2222);
        d_req = 1'b0;
        step();
        m_ack = 1'b1;
        m_rdata = 32'h9999_9999;
        step();
        m_ack = 1'b0;
        checkEq("idleAck.d_ready", d_ready, 0);
        checkEq("idleAck.i_ready", i_ready, 0);
        checkEq("idleAck.d_rdata", d_rdata, 32'h2222_2222);
        step();
        checkEq("idleAck.m_req", m_req, 0);

        // Simultaneous store and fetch: data first, fetch right after
        i_req = 1'b1;
        i_addr = 32'hBFC0_0004;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h8000_0010;
        d_wdata = 32'hDEAD_BEEF;
        d_sel = 4'b0011;
        serveBus("st", 1, 32'h5555_5555, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011);
        checkEq("st.d_ready", d_ready, 1);
        checkEq("st.d_rdataKept", d_rdata, 32'h2222_2222);
        checkEq("st.stallF", stallF, 1);
        d_req = 1'b0;
        d_we = 1'b0;
        step();
        checkEq("st.fetchGrant", m_req, 1);
        checkEq("st.stallFspan", stallF, 1);
        serveBus("st.fetch", 0, 32'h3C1D_0001, 1'b0, 32'hBFC0_0004, '0, 4'hF);
        checkEq("st.i_ready", i_ready, 1);
        checkEq("st.i_rdata", i_rdata, 32'h3C1D_0001);
        i_req = 1'b0;
        step();

        // Starvation guard: four data grants, one fetch, repeated to show the counter cleared
        i_req = 1'b1;
        i_addr = 32'hBFC0_0100;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_2000;
        d_sel = 4'hF;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                serveBus("starve.d", 0, 32'h5000 + k, 1'b0, 32'h0000_2000, '0, 4'hF);
                checkEq("starve.d_ready", d_ready, 1);
                checkEq("starve.d_rdata", d_rdata, 32'h5000 + k);
                checkEq("starve.stallF", stallF, 1);
            end
            serveBus("starve.f", 0, 32'hF000 + r, 1'b0, 32'hBFC0_0100, '0, 4'hF);
            checkEq("starve.i_ready", i_ready, 1);
            checkEq("starve.i_rdata", i_rdata, 32'hF000 + r);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();

        // Flush during IBUSY discards the returned word
        i_req = 1'b1;
        i_addr = 32'h0040_0000;
        step();
        checkEq("flush.grant", m_req, 1);
        step();
        i_flush = 1'b1;
        i_req = 1'b0;
        step();
        i_flush = 1'b0;
        m_ack = 1'b1;
        m_rdata = 32'h1234_5678;
        step();
        m_ack = 1'b0;
        checkEq("flush.noReady", i_ready, 0);
        checkEq("flush.i_rdataKept", i_rdata, 32'hF001);
        checkEq("flush.m_req", m_req, 0);
        step();
        checkEq("flush.noReadyLate", i_ready, 0);
        i_req = 1'b1;
        i_addr = 32'h0040_0040;
        i_flush = 1'b1;
        step();
        checkEq("flush.idleBlock", m_req, 0);
        i_flush = 1'b0;
        serveBus("refetch", 1, 32'hAAAA_5555, 1'b0, 32'h0040_0040, '0, 4'hF);
        checkEq("refetch.i_ready", i_ready, 1);
        checkEq("refetch.i_rdata", i_rdata, 32'hAAAA_5555);
        i_req = 1'b0;
        step();

        // Asynchronous reset in the middle of a data access
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_3000;
        step();
        checkEq("arst.busy", m_req, 1);
        #3;
        rst = 1'b1;
        #1;
        checkEq("arst.m_req", m_req, 0);
        checkEq("arst.d_ready", d_ready, 0);
        checkEq("arst.stallM", stallM, 0);
        checkEq("arst.i_rdata", i_rdata, 0);
        checkEq("arst.d_rdata", d_rdata, 0);
        d_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        checkEq("arst.idle", m_req, 0);
        i_req = 1'b1;
        i_addr = 32'h0000_0100;
        step();
        checkEq("arst.fetchGrant", m_req, 1);
        serveBus("arst.fetch", 0, 32'h0BAD_F00D, 1'b0, 32'h0000_0100, '0, 4'hF);
        checkEq("arst.i_ready", i_ready, 1);
        checkEq("arst.i_rdataNew", i_rdata, 32'h0BAD_F00D);
        i_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
